axi_write_slave: RTL and testbench

AXI write-path slave: accepts one write-address burst on AW, absorbs its data beats on W into an internal word-addressed memory under byte strobes, and returns a single write response on B. Sits on the DUV side of the write address, write data and write response channels, producing the AWREADY/WREADY/BID/BRESP/BVALID signals the top-level bench probes. A debug read port exposes memory contents to the bench scoreboard.

---
 rtl/axi_write_slave_pkg.sv | 40 ++++
 rtl/axi_burst_addr.sv | 37 +++
 rtl/axi_write_slave.sv | 180 ++++++++++++++++++
 tb/tb_axi_write_slave.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_write_slave_pkg.sv
// ---------------------------------------------------------------------------
// axiprotocol: shared AXI definitions for the write-path slave and the
// burst-address helper, which the read-path slave will reuse later.
//   WIDTH  data/address width in bits (byte lanes = WIDTH/8)
//   SIZE   AxSIZE width; AxBURST and xRESP are SIZE-1 bits wide
//   burst_e / resp_e / state_e  protocol and FSM encodings
// ---------------------------------------------------------------------------
package axiprotocol;

    localparam int WIDTH = 32;
    localparam int SIZE  = 3;
    localparam int LANES = WIDTH / 8;

    typedef enum logic [SIZE-2:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    typedef enum logic [SIZE-2:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } state_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [LANES-1:0] len);
        return (len == LANES'(1)) || (len == LANES'(3)) ||
               (len == LANES'(7)) || (len == LANES'(15));
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// ---------------------------------------------------------------------------
// axi_burst_addr: combinational next-beat address for an AXI burst.
//   addr       current beat byte address
//   size       AxSIZE (bytes per beat = 2**size)
//   len        AxLEN (beats minus one)
//   burst      FIXED / INCR / WRAP / reserved
//   next_addr  byte address of the following beat (modulo 2**WIDTH)
// ---------------------------------------------------------------------------
module axi_burst_addr
    import axiprotocol::*;
(
    input  logic [WIDTH-1:0] addr,
    input  logic [SIZE-1:0]  size,
    input  logic [LANES-1:0] len,
    input  burst_e           burst,
    output logic [WIDTH-1:0] next_addr
);

    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] wrap_mask;

    always_comb begin
        inc       = WIDTH'(1) << size;
        // Wrap boundary is the total burst size in bytes; only meaningful
        // when it is a power of two, which legal WRAP lengths guarantee.
        wrap_mask = ((WIDTH'(len) + WIDTH'(1)) * inc) - WIDTH'(1);
        next_addr = addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            // First INCR beat may be unaligned; later beats are aligned.
            BURST_INCR:  next_addr = (addr & ~(inc - WIDTH'(1))) + inc;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((addr + inc) & wrap_mask);
            default:     next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_write_slave.sv
// ---------------------------------------------------------------------------
// axi_write_slave: AXI write-path slave with an internal word memory.
//   clk, reset          clock; synchronous active-low reset
//   AW*                 write address channel (one burst at a time)
//   W*                  write data channel, byte strobes per lane
//   B*                  single write response per burst
//   dbg_addr/dbg_rdata  combinational word read of the memory
// Burst length is counted (AWLEN+1 beats); WLAST is only checked.
// ---------------------------------------------------------------------------
module axi_write_slave
    import axiprotocol::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LANES-1:0]         AWID,
    input  logic [WIDTH-1:0]         AWADDR,
    input  logic [LANES-1:0]         AWLEN,
    input  logic [SIZE-1:0]          AWSIZE,
    input  logic [SIZE-2:0]          AWBURST,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [LANES-1:0]         WID,
    input  logic [WIDTH-1:0]         WDATA,
    input  logic [LANES-1:0]         WSTRB,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [LANES-1:0]         BID,
    output logic [SIZE-2:0]          BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    output logic [WIDTH-1:0]         dbg_rdata
);

    localparam int               IDX_W      = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] ADDR_LIMIT = WIDTH'(DEPTH * 4);

    state_e           state_q,     state_d;
    logic [LANES-1:0] id_q,        id_d;
    logic [WIDTH-1:0] addr_q,      addr_d;
    logic [LANES-1:0] len_q,       len_d;
    logic [SIZE-1:0]  size_q,      size_d;
    burst_e           burst_q,     burst_d;
    logic [LANES-1:0] beat_q,      beat_d;
    logic             decerr_q,    decerr_d;
    logic             proto_err_q, proto_err_d;

    logic [WIDTH-1:0] next_addr;
    logic             cfg_err;
    logic             in_range;
    logic             last_beat;
    logic             w_hs;
    logic             mem_we;
    resp_e            resp;

    logic [WIDTH-1:0] mem [DEPTH];

    axi_burst_addr u_burst_addr (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // Burst-shape errors are a pure function of the latched AW fields and
    // suppress every write of the burst; WID/WLAST errors only taint BRESP.
    assign cfg_err   = (burst_q == BURST_RSVD) ||
                       ((WIDTH'(1) << size_q) > WIDTH'(LANES)) ||
                       ((burst_q == BURST_WRAP) && !wrap_len_ok(len_q));
    assign in_range  = addr_q < ADDR_LIMIT;
    assign last_beat = beat_q == len_q;
    assign w_hs      = WVALID && (state_q == ST_DATA);
    assign mem_we    = w_hs && !cfg_err && in_range;

    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        decerr_d    = decerr_q;
        proto_err_d = proto_err_q;
        case (state_q)
            ST_IDLE: begin
                if (AWVALID) begin
                    id_d        = AWID;
                    addr_d      = AWADDR;
                    len_d       = AWLEN;
                    size_d      = AWSIZE;
                    burst_d     = burst_e'(AWBURST);
                    beat_d      = '0;
                    decerr_d    = 1'b0;
                    proto_err_d = 1'b0;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (WVALID) begin
                    addr_d = next_addr;
                    beat_d = beat_q + LANES'(1);
                    if (!in_range) begin
                        decerr_d = 1'b1;
                    end
                    if ((WID != id_q) || (WLAST != last_beat)) begin
                        proto_err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (BREADY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= BURST_FIXED;
            beat_q      <= '0;
            decerr_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            decerr_q    <= decerr_d;
            proto_err_q <= proto_err_d;
        end
    end

    // NOTE: the memory is deliberately left out of reset so it maps onto a RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (WSTRB[i]) begin
                    mem[addr_q[IDX_W+1:2]][i*8 +: 8] <= WDATA[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        resp = RESP_OKAY;
        if (decerr_q) begin
            resp = RESP_DECERR;
        end else if (cfg_err || proto_err_q) begin
            resp = RESP_SLVERR;
        end
    end

    assign AWREADY   = (state_q == ST_IDLE);
    assign WREADY    = (state_q == ST_DATA);
    assign BVALID    = (state_q == ST_RESP);
    assign BID       = (state_q == ST_RESP) ? id_q : '0;
    assign BRESP     = (state_q == ST_RESP) ? resp : RESP_OKAY;
    assign dbg_rdata = mem[dbg_addr];

endmodule

// File: tb/tb_axi_write_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_write_slave: self-checking bench for axi_write_slave.
// Directed table of bursts, hand-written multi-cycle sequences (FIXED strobe
// merge, BREADY back-pressure with a pending AW, reset mid-burst), then
// random bursts checked against a memory/response model built from address
// arithmetic over the whole burst.
// ---------------------------------------------------------------------------
module tb_axi_write_slave;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [3:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [3:0]  WID = '0;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [7:0]  dbg_addr = '0;
    logic [31:0] dbg_rdata;

    always #5 clk = ~clk;

    axi_write_slave #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .AWID      (AWID),
        .AWADDR    (AWADDR),
        .AWLEN     (AWLEN),
        .AWSIZE    (AWSIZE),
        .AWBURST   (AWBURST),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WID       (WID),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WLAST     (WLAST),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BID       (BID),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] bd_data [16];
    logic [3:0]  bd_strb [16];
    logic [3:0]  bd_wid  [16];
    logic        bd_last [16];

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] data0;
        logic [3:0]  strb;
        bit          bad_wlast;
        bit          bad_wid;
        logic [1:0]  exp_resp;
        int          chk_idx;
        logic [31:0] chk_val;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem(input string name, input int idx, input logic [31:0] exp);
        dbg_addr = idx[7:0];
        #1;
        check(name, dbg_rdata, exp);
    endtask

    // Reference: enumerate every beat address of the burst directly, then
    // apply writes and derive the response from the whole-burst picture.
    task automatic model_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst, output logic [1:0] resp);
        logic [31:0] inc, bound, base, a;
        bit dec, bad, cfg;
        dec   = 1'b0;
        bad   = 1'b0;
        inc   = 32'd1 << size;
        bound = (32'(len) + 32'd1) * inc;
        base  = addr - (addr % bound);
        cfg   = (burst == 2'd3) || (inc > 32'd4) ||
                ((burst == 2'd2) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
        for (int k = 0; k <= int'(len); k++) begin
            case (burst)
                2'd1:    a = (k == 0) ? addr : (addr - (addr % inc)) + 32'(k) * inc;
                2'd2:    a = (k == 0) ? addr : base + ((addr - base + 32'(k) * inc) % bound);
                default: a = addr;
            endcase
            if (a >= 32'(DEPTH * 4)) begin
                dec = 1'b1;
            end else if (!cfg) begin
                for (int i = 0; i < 4; i++) begin
                    if (bd_strb[k][i]) model_mem[a[9:2]][i*8 +: 8] = bd_data[k][i*8 +: 8];
                end
            end
            if ((bd_wid[k] != id) || (bd_last[k] != (k == int'(len)))) bad = 1'b1;
        end
        resp = dec ? 2'd3 : ((cfg || bad) ? 2'd2 : 2'd0);
    endtask

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
        AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin tick(); n++; end
        check("awready_wait", AWREADY, 1);
        tick();
        AWVALID = 1'b0;
        check("wready_after_aw", WREADY, 1);
        check("awready_in_data", AWREADY, 0);
    endtask

    task automatic w_phase(input logic [3:0] len, input int first, input int last_k, input bit gaps);
        int n;
        for (int k = first; k <= last_k; k++) begin
            if (gaps && $urandom_range(3) == 0) begin
                WVALID = 1'b0;
                tick();
            end
            WDATA = bd_data[k]; WSTRB = bd_strb[k]; WID = bd_wid[k]; WLAST = bd_last[k];
            WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < 50) begin tick(); n++; end
            check("wready_wait", WREADY, 1);
            tick();
            WVALID = 1'b0;
            if (k < int'(len)) begin
                check("wready_mid_burst", WREADY, 1);
            end else begin
                check("bvalid_after_last", BVALID, 1);
                check("wready_after_last", WREADY, 0);
            end
        end
    endtask

    task automatic b_phase(input logic [3:0] exp_id, input logic [1:0] exp_resp, input int delay,
                           output logic [1:0] got);
        for (int d = 0; d < delay; d++) begin
            check("bvalid_hold", BVALID, 1);
            check("bid_hold", BID, exp_id);
            check("bresp_hold", BRESP, exp_resp);
            check("awready_in_resp", AWREADY, 0);
            tick();
        end
        check("bvalid", BVALID, 1);
        check("bid", BID, exp_id);
        check("bresp", BRESP, exp_resp);
        got = BRESP;
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("bvalid_cleared", BVALID, 0);
        check("awready_after_b", AWREADY, 1);
    endtask

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int delay,
                             input bit gaps, output logic [1:0] got);
        logic [1:0] exp;
        model_burst(id, addr, len, size, burst, exp);
        aw_phase(id, addr, len, size, burst);
        w_phase(len, 0, int'(len), gaps);
        b_phase(id, exp, delay, got);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  got, exp1, exp2;
        logic [3:0]  id, len;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          r;

        //         id     addr        len   size  burst data0          strb  wl    wid   resp  idx  value
        vecs[0] = '{4'd5,  32'h010, 4'd3, 3'd2, 2'd1, 32'h000000A0, 4'hF, 1'b0, 1'b0, 2'd0, 7,   32'h000000A3};
        vecs[1] = '{4'd6,  32'h038, 4'd3, 3'd2, 2'd2, 32'h000000B0, 4'hF, 1'b0, 1'b0, 2'd0, 12,  32'h000000B2};
        vecs[2] = '{4'd1,  32'h400, 4'd0, 3'd2, 2'd1, 32'h000000C0, 4'hF, 1'b0, 1'b0, 2'd3, 0,   32'h00000000};
        vecs[3] = '{4'd2,  32'h040, 4'd1, 3'd2, 2'd3, 32'h000000D0, 4'hF, 1'b0, 1'b0, 2'd2, 16,  32'h00000000};
        vecs[4] = '{4'd3,  32'h050, 4'd1, 3'd2, 2'd1, 32'h000000E0, 4'hF, 1'b1, 1'b0, 2'd2, 21,  32'h000000E1};
        vecs[5] = '{4'd4,  32'h060, 4'd0, 3'd3, 2'd1, 32'h000000F0, 4'hF, 1'b0, 1'b0, 2'd2, 24,  32'h00000000};
        vecs[6] = '{4'd7,  32'h070, 4'd2, 3'd2, 2'd2, 32'h00000070, 4'hF, 1'b0, 1'b0, 2'd2, 28,  32'h00000000};
        vecs[7] = '{4'd8,  32'h3F8, 4'd3, 3'd2, 2'd1, 32'h000000F0, 4'hF, 1'b0, 1'b0, 2'd3, 255, 32'h000000F1};
        vecs[8] = '{4'd9,  32'h081, 4'd3, 3'd0, 2'd1, 32'h12345600, 4'hF, 1'b0, 1'b0, 2'd0, 32,  32'h12345602};
        vecs[9] = '{4'd10, 32'h090, 4'd1, 3'd2, 2'd1, 32'h00000090, 4'hF, 1'b0, 1'b1, 2'd2, 37,  32'h00000091};

        // Reset state.
        tick();
        tick();
        reset = 1'b1;
        check("rst_awready", AWREADY, 1);
        check("rst_wready", WREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_bid", BID, 0);
        check("rst_bresp", BRESP, 0);

        // The memory powers up undefined: fill it with zeros first.
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 16; k++) begin
                bd_data[k] = '0; bd_strb[k] = 4'hF; bd_wid[k] = 4'd0; bd_last[k] = (k == 15);
            end
            run_burst(4'd0, 32'(b * 64), 4'd15, 3'd2, 2'd1, 0, 1'b0, got);
        end

        // Directed table.
        for (int v = 0; v < 10; v++) begin
            for (int k = 0; k < 16; k++) begin
                bd_data[k] = vecs[v].data0 + 32'(k);
                bd_strb[k] = vecs[v].strb;
                bd_wid[k]  = (vecs[v].bad_wid && k == 0) ? (vecs[v].id ^ 4'd1) : vecs[v].id;
                bd_last[k] = (k == int'(vecs[v].len)) ^ (vecs[v].bad_wlast && k == int'(vecs[v].len));
            end
            run_burst(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, 0, 1'b0, got);
            check($sformatf("vec%0d_resp", v), got, vecs[v].exp_resp);
            check_mem($sformatf("vec%0d_mem", v), vecs[v].chk_idx, vecs[v].chk_val);
        end
        check_mem("wrap_order_0e", 14, 32'h000000B0);
        check_mem("wrap_order_0d", 13, 32'h000000B3);
        check_mem("decerr_alias_word1", 1, 32'h00000000);

        // FIXED burst merging two strobe patterns into one word.
        bd_data[0] = 32'h11111111; bd_strb[0] = 4'h3; bd_wid[0] = 4'd1; bd_last[0] = 1'b0;
        bd_data[1] = 32'h22222222; bd_strb[1] = 4'hC; bd_wid[1] = 4'd1; bd_last[1] = 1'b1;
        run_burst(4'd1, 32'h20, 4'd1, 3'd2, 2'd0, 0, 1'b0, got);
        check("fixed_resp", got, 2'd0);
        check_mem("fixed_merge", 8, 32'h22221111);

        // BREADY low 5 cycles with the next AW already pending.
        for (int k = 0; k < 2; k++) begin
            bd_data[k] = 32'h5A5A0000 + 32'(k); bd_strb[k] = 4'hF;
            bd_wid[k] = (k == 1) ? 4'd8 : 4'd9; bd_last[k] = (k == 1);
        end
        model_burst(4'd9, 32'hC0, 4'd1, 3'd2, 2'd1, exp1);
        aw_phase(4'd9, 32'hC0, 4'd1, 3'd2, 2'd1);
        w_phase(4'd1, 0, 1, 1'b0);
        AWID = 4'd3; AWADDR = 32'hD0; AWLEN = 4'd0; AWSIZE = 3'd2; AWBURST = 2'd1;
        AWVALID = 1'b1;
        for (int d = 0; d < 5; d++) begin
            check("hold_bvalid", BVALID, 1);
            check("hold_bid", BID, 4'd9);
            check("hold_bresp", BRESP, exp1);
            check("hold_awready", AWREADY, 0);
            tick();
        end
        check("hold_bresp_slverr", BRESP, 2'd2);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("hold_awready_next", AWREADY, 1);
        check("hold_bvalid_clear", BVALID, 0);
        tick();
        AWVALID = 1'b0;
        check("hold_aw_accepted", WREADY, 1);
        bd_data[0] = 32'h0D0D0D0D; bd_strb[0] = 4'hF; bd_wid[0] = 4'd3; bd_last[0] = 1'b1;
        model_burst(4'd3, 32'hD0, 4'd0, 3'd2, 2'd1, exp2);
        w_phase(4'd0, 0, 0, 1'b0);
        b_phase(4'd3, exp2, 0, got);
        check("hold2_resp", got, 2'd0);
        check_mem("hold2_mem", 52, 32'h0D0D0D0D);

        // Reset after beat 2 of a 4-beat burst.
        for (int k = 0; k < 4; k++) begin
            bd_data[k] = 32'h77000000 + 32'(k); bd_strb[k] = 4'hF; bd_wid[k] = 4'd2; bd_last[k] = (k == 3);
        end
        aw_phase(4'd2, 32'hA0, 4'd3, 3'd2, 2'd1);
        w_phase(4'd3, 0, 1, 1'b0);
        model_mem[40] = 32'h77000000;
        model_mem[41] = 32'h77000001;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_awready", AWREADY, 1);
        check("midrst_wready", WREADY, 0);
        check("midrst_bvalid", BVALID, 0);
        check("midrst_bid", BID, 0);
        check("midrst_bresp", BRESP, 0);
        check_mem("midrst_beat1", 40, 32'h77000000);
        check_mem("midrst_beat2", 41, 32'h77000001);
        check_mem("midrst_beat3", 42, 32'h00000000);

        // WVALID while idle is ignored.
        WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WID = 4'd0; WLAST = 1'b1; WVALID = 1'b1;
        for (int d = 0; d < 3; d++) begin
            check("idle_wready", WREADY, 0);
            tick();
        end
        WVALID = 1'b0;

        // Random bursts against the model.
        for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(9));
            burst = (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : (r < 9) ? 2'd0 : 2'd3;
            size = ($urandom_range(7) == 0) ? 3'd3 : 3'($urandom_range(2));
            len = 4'($urandom_range(15));
            if (burst == 2'd2 && $urandom_range(4) != 0) begin
                case ($urandom_range(3))
                    0:       len = 4'd1;
                    1:       len = 4'd3;
                    2:       len = 4'd7;
                    default: len = 4'd15;
                endcase
            end
            addr = 32'($urandom_range(32'h43F));
            if (burst == 2'd2 && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) begin
                addr = addr & 32'hFF;
                size = 3'($urandom_range(2));
            end
            id = 4'($urandom);
            for (int k = 0; k < 16; k++) begin
                bd_data[k] = $urandom;
                bd_strb[k] = 4'($urandom);
                bd_wid[k]  = ($urandom_range(11) == 0) ? id + 4'd1 : id;
                bd_last[k] = (k == int'(len)) ^ ($urandom_range(11) == 0);
            end
            run_burst(id, addr, len, size, burst, int'($urandom_range(3)), 1'b1, got);
            check_mem("rand_first_word", int'(addr[9:2]), model_mem[addr[9:2]]);
        end

        // Whole-memory comparison.
        for (int i = 0; i < DEPTH; i++) begin
            check_mem($sformatf("mem[%0d]", i), i, model_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
